// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Memory is addressed in 4-bit cells; one instruction spans four consecutive cells.
package fetch_stage_pkg;

  localparam int WORD_LEN        = 16;
  localparam int MEM_CELL_SIZE   = 4;
  localparam int INSTR_MEM_SIZE  = 32;
  localparam int CELLS_PER_INSTR = WORD_LEN / MEM_CELL_SIZE;

  localparam logic [WORD_LEN-1:0] NOP_INSTR = '0;

  typedef enum logic {
    FETCH_WARMUP = 1'b0,
    FETCH_RUN    = 1'b1
  } fetchState_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush injects a bubble, load captures a fetched word,
// otherwise every field holds (hazard freeze).
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int                WORD_W   = WORD_LEN,
  parameter logic [WORD_W-1:0] NOP_WORD = NOP_INSTR
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] pc_i,
  input  logic [WORD_W-1:0] pc_next_i,
  input  logic [WORD_W-1:0] instr_i,
  output logic [WORD_W-1:0] pc_o,
  output logic [WORD_W-1:0] pc_next_o,
  output logic [WORD_W-1:0] instr_o,
  output logic              valid_o
);

  logic [WORD_W-1:0] pc_q;
  logic [WORD_W-1:0] pcNext_q;
  logic [WORD_W-1:0] instr_q;
  logic              valid_q;

  // Reset and flush both leave a bubble; flush wins over load so a branch
  // squashes the word fetched down the wrong path.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      pc_q     <= '0;
      pcNext_q <= '0;
      instr_q  <= NOP_WORD;
      valid_q  <= 1'b0;
    end else if (load_i) begin
      pc_q     <= pc_i;
      pcNext_q <= pc_next_i;
      instr_q  <= instr_i;
      valid_q  <= 1'b1;
    end
  end

  assign pc_o      = pc_q;
  assign pc_next_o = pcNext_q;
  assign instr_o   = instr_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, wrapping incrementer and warm-up FSM,
// feeding the IF/ID register consumed by decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                WORD_W     = WORD_LEN,
  parameter int                INSTR_STEP = CELLS_PER_INSTR,
  parameter int                MEM_SIZE   = INSTR_MEM_SIZE,
  parameter logic [WORD_W-1:0] RESET_PC   = '0,
  parameter logic [WORD_W-1:0] NOP_WORD   = NOP_INSTR
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              freeze_i,
  input  logic              branch_taken_i,
  input  logic [WORD_W-1:0] branch_addr_i,
  output logic [WORD_W-1:0] instr_addr_o,
  input  logic [WORD_W-1:0] instr_i,
  output logic [WORD_W-1:0] pc_id_o,
  output logic [WORD_W-1:0] pc_next_id_o,
  output logic [WORD_W-1:0] instr_id_o,
  output logic              valid_id_o
);

  // MEM_SIZE is a power of two, so modulo reduces to masking the low bits.
  localparam logic [WORD_W-1:0] ADDR_MASK = WORD_W'(MEM_SIZE - 1);
  localparam logic [WORD_W-1:0] STEP      = WORD_W'(INSTR_STEP);

  fetchState_e       state_q;
  logic [WORD_W-1:0] pc_q;
  logic [WORD_W-1:0] pc_d;
  logic [WORD_W-1:0] pcPlusStep;
  logic [WORD_W-1:0] branchTarget;
  logic              inRun;
  logic              ifIdFlush;
  logic              ifIdLoad;

  assign pcPlusStep   = (pc_q + STEP) & ADDR_MASK;
  assign branchTarget = branch_addr_i & ADDR_MASK;
  assign inRun        = (state_q == FETCH_RUN);

  // Branch beats freeze; warm-up holds the PC regardless of freeze.
  always_comb begin
    pc_d = pc_q;
    if (inRun) begin
      if (branch_taken_i) begin
        pc_d = branchTarget;
      end else if (!freeze_i) begin
        pc_d = pcPlusStep;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FETCH_WARMUP;
      pc_q    <= RESET_PC;
    end else begin
      case (state_q)
        FETCH_WARMUP: state_q <= FETCH_RUN;
        FETCH_RUN:    state_q <= FETCH_RUN;
        default:      state_q <= FETCH_WARMUP;
      endcase
      pc_q <= pc_d;
    end
  end

  // The warm-up cycle pushes a bubble because the memory image is still settling.
  assign ifIdFlush = !inRun || branch_taken_i;
  assign ifIdLoad  = inRun && !freeze_i;

  assign instr_addr_o = pc_q;

  if_id_reg #(
    .WORD_W   (WORD_W),
    .NOP_WORD (NOP_WORD)
  ) u_if_id_reg (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (ifIdFlush),
    .load_i    (ifIdLoad),
    .pc_i      (pc_q),
    .pc_next_i (pcPlusStep),
    .instr_i   (instr_i),
    .pc_o      (pc_id_o),
    .pc_next_o (pc_next_id_o),
    .instr_o   (instr_id_o),
    .valid_o   (valid_id_o)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: model instruction memory, directed scenarios, then
// random freeze/branch/reset traffic checked against a cycle-level model.
module tb_fetch_stage;

  localparam int MEM_CELLS = 32;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branchTaken;
  logic [15:0] branchAddr;
  logic [15:0] instrAddr;
  logic [15:0] instrIn;
  logic [15:0] pcId;
  logic [15:0] pcNextId;
  logic [15:0] instrId;
  logic        validId;

  logic [3:0] mem [MEM_CELLS];

  int assertCount = 0;
  int failCount   = 0;

  // Reference model state
  int          mPc;
  bit          mWarm;
  int          mPcId;
  int          mPcNextId;
  logic [15:0] mInstrId;
  bit          mValid;

  fetch_stage dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .freeze_i       (freeze),
    .branch_taken_i (branchTaken),
    .branch_addr_i  (branchAddr),
    .instr_addr_o   (instrAddr),
    .instr_i        (instrIn),
    .pc_id_o        (pcId),
    .pc_next_id_o   (pcNextId),
    .instr_id_o     (instrId),
    .valid_id_o     (validId)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] memWord(input int addr);
    int a;
    a = addr % MEM_CELLS;
    return {mem[a], mem[(a + 1) % MEM_CELLS], mem[(a + 2) % MEM_CELLS], mem[(a + 3) % MEM_CELLS]};
  endfunction

  always_comb instrIn = memWord(int'(instrAddr[4:0]));

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".instr_addr"}, 32'(instrAddr), 32'(mPc));
    checkOutput({tag, ".pc_id"},      32'(pcId),      32'(mPcId));
    checkOutput({tag, ".pc_next_id"}, 32'(pcNextId),  32'(mPcNextId));
    checkOutput({tag, ".instr_id"},   32'(instrId),   32'(mInstrId));
    checkOutput({tag, ".valid_id"},   32'(validId),   32'(mValid));
  endtask

  // Drives one cycle, advances the model by the same rules, samples 1ns after the edge.
  task automatic applyStimulus(input bit r, input bit f, input bit b, input logic [15:0] addr);
    rst         = r;
    freeze      = f;
    branchTaken = b;
    branchAddr  = addr;
    @(posedge clk);
    if (r) begin
      mPc = 0; mWarm = 1; mPcId = 0; mPcNextId = 0; mInstrId = 16'h0; mValid = 0;
    end else if (mWarm) begin
      mWarm = 0; mPcId = 0; mPcNextId = 0; mInstrId = 16'h0; mValid = 0;
    end else if (b) begin
      mPc = int'(addr) % MEM_CELLS;
      mPcId = 0; mPcNextId = 0; mInstrId = 16'h0; mValid = 0;
    end else if (!f) begin
      mPcId     = mPc;
      mPcNextId = (mPc + 4) % MEM_CELLS;
      mInstrId  = memWord(mPc);
      mValid    = 1;
      mPc       = (mPc + 4) % MEM_CELLS;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < MEM_CELLS; i++) mem[i] = 4'($urandom);
    rst = 1'b1; freeze = 1'b0; branchTaken = 1'b0; branchAddr = '0;
    mPc = 0; mWarm = 1; mPcId = 0; mPcNextId = 0; mInstrId = 16'h0; mValid = 0;

    // Reset held two clocks, with freeze asserted to show it is overridden
    applyStimulus(1, 1, 0, 16'h0);
    applyStimulus(1, 0, 0, 16'h0);
    checkAll("reset");
    checkOutput("reset.addr_zero", 32'(instrAddr), 32'd0);
    checkOutput("reset.instr_nop", 32'(instrId), 32'd0);

    // Warm-up cycle, freeze ignored
    applyStimulus(0, 1, 0, 16'h0);
    checkAll("warmup");
    checkOutput("warmup.valid", 32'(validId), 32'd0);
    checkOutput("warmup.pc_hold", 32'(instrAddr), 32'd0);

    // Straight-line fetch
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 16'h0);
      checkAll("straight");
      checkOutput("straight.pc_id", 32'(pcId), 32'(4 * i));
      checkOutput("straight.pc_next_id", 32'(pcNextId), 32'(4 * i + 4));
      checkOutput("straight.instr_id", 32'(instrId), 32'(memWord(4 * i)));
      checkOutput("straight.valid", 32'(validId), 32'd1);
    end

    // Freeze at PC=8 for three clocks
    applyStimulus(0, 0, 1, 16'd8);
    applyStimulus(0, 0, 0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 16'h0);
      checkAll("freeze");
      checkOutput("freeze.addr_hold", 32'(instrAddr), 32'd12);
    end
    applyStimulus(0, 0, 1, 16'd8);
    checkOutput("freeze.branch_flush", 32'(validId), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 16'h0);
      checkAll("freeze8");
      checkOutput("freeze8.addr_hold", 32'(instrAddr), 32'd8);
    end
    applyStimulus(0, 0, 0, 16'h0);
    checkAll("unfreeze");
    checkOutput("unfreeze.pc_id", 32'(pcId), 32'd8);

    // Branch and freeze in the same cycle
    applyStimulus(0, 1, 1, 16'd20);
    checkAll("brfreeze");
    checkOutput("brfreeze.addr", 32'(instrAddr), 32'd20);
    checkOutput("brfreeze.valid", 32'(validId), 32'd0);
    checkOutput("brfreeze.instr", 32'(instrId), 32'd0);
    applyStimulus(0, 0, 0, 16'h0);
    checkAll("brtarget");
    checkOutput("brtarget.pc_id", 32'(pcId), 32'd20);
    checkOutput("brtarget.instr", 32'(instrId), 32'(memWord(20)));

    // Wrap-around of incrementer and masked branch target
    applyStimulus(0, 0, 1, 16'd28);
    applyStimulus(0, 0, 0, 16'h0);
    checkAll("wrap");
    checkOutput("wrap.addr", 32'(instrAddr), 32'd0);
    checkOutput("wrap.pc_next_id", 32'(pcNextId), 32'd0);
    applyStimulus(0, 0, 1, 16'd36);
    checkOutput("wrap.branch_mask", 32'(instrAddr), 32'd4);
    applyStimulus(0, 0, 1, 16'd6);
    checkOutput("misaligned.addr", 32'(instrAddr), 32'd6);
    applyStimulus(0, 0, 0, 16'h0);
    checkAll("misaligned");

    // Reset in the middle of a branch
    applyStimulus(1, 0, 1, 16'd12);
    checkAll("midreset");
    checkOutput("midreset.addr", 32'(instrAddr), 32'd0);
    checkOutput("midreset.valid", 32'(validId), 32'd0);
    applyStimulus(0, 0, 1, 16'd12);
    checkAll("midreset.warmup");
    checkOutput("midreset.warmup_addr", 32'(instrAddr), 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bit r;
      bit f;
      bit b;
      r = ($urandom_range(0, 63) == 0);
      f = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 7) == 0);
      applyStimulus(r, f, b, 16'($urandom));
      checkAll("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
